// File: rtl/cu_pkg.sv
// Shared definitions for the control sequencer: opcode map, control-word layout,
// sequencer states and per-opcode sequencing classes.
package cu_pkg;

   localparam int unsigned CTL_W = 23;

   // Bit positions inside the ctl word
   typedef enum logic [4:0] {
      CtlPcOut, CtlZloOut, CtlZhiOut, CtlMdrOut, CtlMarEnable, CtlZEnable, CtlPcEnable,
      CtlMdrEnable, CtlRead, CtlIrEnable, CtlYEnable, CtlPcIncrement, CtlLoEnable,
      CtlHiEnable, CtlRIn, CtlROut, CtlGra, CtlGrb, CtlGrc, CtlBaOut, CtlCSignExtOut,
      CtlRamWrite, CtlConEnable
   } ctl_bit_e;

   localparam logic [4:0] OpLd   = 5'b00000;
   localparam logic [4:0] OpLdi  = 5'b00001;
   localparam logic [4:0] OpSt   = 5'b00010;
   localparam logic [4:0] OpAdd  = 5'b00011;
   localparam logic [4:0] OpSub  = 5'b00100;
   localparam logic [4:0] OpAnd  = 5'b00101;
   localparam logic [4:0] OpOr   = 5'b00110;
   localparam logic [4:0] OpShr  = 5'b00111;
   localparam logic [4:0] OpShra = 5'b01000;
   localparam logic [4:0] OpShl  = 5'b01001;
   localparam logic [4:0] OpRor  = 5'b01010;
   localparam logic [4:0] OpRol  = 5'b01011;
   localparam logic [4:0] OpAddi = 5'b01100;
   localparam logic [4:0] OpAndi = 5'b01101;
   localparam logic [4:0] OpOri  = 5'b01110;
   localparam logic [4:0] OpMul  = 5'b01111;
   localparam logic [4:0] OpDiv  = 5'b10000;
   localparam logic [4:0] OpNeg  = 5'b10001;
   localparam logic [4:0] OpNot  = 5'b10010;
   localparam logic [4:0] OpHalt = 5'b11011;

   // T0..T7 encode their own step index in the low bits
   typedef enum logic [3:0] {
      StT0 = 4'd0, StT1 = 4'd1, StT2 = 4'd2, StT3 = 4'd3,
      StT4 = 4'd4, StT5 = 4'd5, StT6 = 4'd6, StT7 = 4'd7,
      StReset = 4'd8, StHalt = 4'd9
   } state_e;

   typedef enum logic [3:0] {
      ClsAluRr, ClsAluImm, ClsLdi, ClsLd, ClsSt, ClsMulDiv, ClsNegNot, ClsHalt, ClsIllegal
   } op_class_e;

   function automatic op_class_e decode_op(input logic [4:0] op);
      op_class_e cls;
      case (op)
         OpAdd, OpSub, OpAnd, OpOr, OpShr,
         OpShra, OpShl, OpRor, OpRol:   cls = ClsAluRr;
         OpAddi, OpAndi, OpOri:         cls = ClsAluImm;
         OpLdi:                         cls = ClsLdi;
         OpLd:                          cls = ClsLd;
         OpSt:                          cls = ClsSt;
         OpMul, OpDiv:                  cls = ClsMulDiv;
         OpNeg, OpNot:                  cls = ClsNegNot;
         OpHalt:                        cls = ClsHalt;
         default:                       cls = ClsIllegal;
      endcase
      return cls;
   endfunction

   // Index of the final T-step for each class
   function automatic logic [2:0] last_step(input op_class_e cls);
      logic [2:0] t;
      case (cls)
         ClsLd, ClsSt: t = 3'd7;
         ClsMulDiv:    t = 3'd6;
         ClsNegNot:    t = 3'd4;
         ClsHalt:      t = 3'd2;
         ClsIllegal:   t = 3'd3;
         default:      t = 3'd5;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/step_timer.sv
// Holds each T-step for STEP_CYCLES clocks; step_done marks the last clock of a step,
// step_first the first one.
module step_timer #(
   parameter int unsigned STEP_CYCLES = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   output logic step_done,
   output logic step_first
);

   localparam logic [2:0] LastCnt = 3'(STEP_CYCLES - 1);

   logic [2:0] cnt_q, cnt_d;

   assign step_done  = en && (cnt_q == LastCnt);
   assign step_first = en && (cnt_q == 3'd0);

   always_comb begin
      cnt_d = '0;
      if (en && !step_done) begin
         cnt_d = cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-step control sequencer: common fetch in T0-T2, opcode-specific execute in
// T3-T7, with halt/resume handling at instruction boundaries.
module control_sequencer
   import cu_pkg::*;
#(
   parameter int unsigned OPCODE_W    = 5,
   parameter int unsigned STEP_CYCLES = 2
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [31:0]         ir,
   input  logic                stop,
   input  logic                resume,
   output logic [CTL_W-1:0]    ctl,
   output logic [OPCODE_W-1:0] alu_op,
   output logic [3:0]          step,
   output logic                running,
   output logic                illegal
);

   state_e              state_q, state_d;
   op_class_e           cls;
   logic [OPCODE_W-1:0] opcode;
   logic [2:0]          t_idx;
   logic                t_active;
   logic                step_done;
   logic                step_first;
   logic                unused_ir;

   assign opcode    = ir[31 -: OPCODE_W];
   assign unused_ir = ^ir[31-OPCODE_W:0];
   assign cls       = decode_op(5'(opcode));
   assign t_active  = (state_q != StReset) && (state_q != StHalt);
   assign t_idx     = state_q[2:0];

   step_timer #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_step_timer (
      .clk       (clk),
      .clr       (clr),
      .en        (t_active),
      .step_done (step_done),
      .step_first(step_first)
   );

   // The halt decision at the end of T2 relies on ir having been loaded during T2.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StReset: state_d = StT0;
         StHalt: begin
            if (resume && !stop) state_d = StT0;
         end
         default: begin
            if (step_done) begin
               if (t_idx == last_step(cls)) begin
                  state_d = (stop || cls == ClsHalt) ? StHalt : StT0;
               end else begin
                  state_d = state_e'({1'b0, t_idx + 3'd1});
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= StReset;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      ctl     = '0;
      alu_op  = '0;
      step    = '0;
      running = t_active;
      illegal = 1'b0;
      if (t_active) begin
         step = {1'b0, t_idx};
         // T0 selects add so the ALU produces PC+1
         if (t_idx == 3'd0) begin
            alu_op = OPCODE_W'(OpAdd);
         end else if (t_idx >= 3'd3) begin
            alu_op = opcode;
         end
         unique case (t_idx)
            3'd0: begin
               ctl[CtlPcOut] = 1'b1;  ctl[CtlMarEnable]   = 1'b1;
               ctl[CtlZEnable] = 1'b1; ctl[CtlPcIncrement] = 1'b1;
            end
            3'd1: begin
               ctl[CtlZloOut] = 1'b1; ctl[CtlPcEnable]  = 1'b1;
               ctl[CtlRead]   = 1'b1; ctl[CtlMdrEnable] = 1'b1;
            end
            3'd2: begin
               ctl[CtlMdrOut] = 1'b1; ctl[CtlIrEnable] = 1'b1;
            end
            default: begin
               unique case (cls)
                  ClsAluRr, ClsAluImm, ClsLdi: begin
                     if (t_idx == 3'd3) begin
                        ctl[CtlGrb] = 1'b1; ctl[CtlYEnable] = 1'b1;
                        if (cls == ClsLdi) ctl[CtlBaOut] = 1'b1;
                        else               ctl[CtlROut]  = 1'b1;
                     end else if (t_idx == 3'd4) begin
                        ctl[CtlZEnable] = 1'b1;
                        if (cls == ClsAluRr) begin
                           ctl[CtlGrc] = 1'b1; ctl[CtlROut] = 1'b1;
                        end else begin
                           ctl[CtlCSignExtOut] = 1'b1;
                        end
                     end else if (t_idx == 3'd5) begin
                        ctl[CtlZloOut] = 1'b1; ctl[CtlGra] = 1'b1; ctl[CtlRIn] = 1'b1;
                     end
                  end
                  ClsLd, ClsSt: begin
                     unique case (t_idx)
                        3'd3: begin
                           ctl[CtlGrb] = 1'b1; ctl[CtlBaOut] = 1'b1; ctl[CtlYEnable] = 1'b1;
                        end
                        3'd4: begin
                           ctl[CtlCSignExtOut] = 1'b1; ctl[CtlZEnable] = 1'b1;
                        end
                        3'd5: begin
                           ctl[CtlZloOut] = 1'b1; ctl[CtlMarEnable] = 1'b1;
                        end
                        3'd6: begin
                           ctl[CtlMdrEnable] = 1'b1;
                           if (cls == ClsLd) begin
                              ctl[CtlRead] = 1'b1;
                           end else begin
                              ctl[CtlGra] = 1'b1; ctl[CtlROut] = 1'b1;
                           end
                        end
                        default: begin
                           if (cls == ClsLd) begin
                              ctl[CtlMdrOut] = 1'b1; ctl[CtlGra] = 1'b1; ctl[CtlRIn] = 1'b1;
                           end else begin
                              ctl[CtlRamWrite] = 1'b1;
                           end
                        end
                     endcase
                  end
                  ClsMulDiv: begin
                     if (t_idx == 3'd3) begin
                        ctl[CtlGra] = 1'b1; ctl[CtlROut] = 1'b1; ctl[CtlYEnable] = 1'b1;
                     end else if (t_idx == 3'd4) begin
                        ctl[CtlGrb] = 1'b1; ctl[CtlROut] = 1'b1; ctl[CtlZEnable] = 1'b1;
                     end else if (t_idx == 3'd5) begin
                        ctl[CtlZloOut] = 1'b1; ctl[CtlLoEnable] = 1'b1;
                     end else if (t_idx == 3'd6) begin
                        ctl[CtlZhiOut] = 1'b1; ctl[CtlHiEnable] = 1'b1;
                     end
                  end
                  ClsNegNot: begin
                     if (t_idx == 3'd3) begin
                        ctl[CtlGrb] = 1'b1; ctl[CtlROut] = 1'b1; ctl[CtlZEnable] = 1'b1;
                     end else if (t_idx == 3'd4) begin
                        ctl[CtlZloOut] = 1'b1; ctl[CtlGra] = 1'b1; ctl[CtlRIn] = 1'b1;
                     end
                  end
                  ClsIllegal: illegal = step_first && (t_idx == 3'd3);
                  default: ;
               endcase
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instruction stream, a cycle-level reference model
// checked every negedge, plus literal expectations at hand-picked points.
module tb_control_sequencer;

   localparam int Sc = 3;

   // ctl bit positions in interface order
   localparam int PcOut = 0,  ZloOut = 1,  ZhiOut = 2,  MdrOut = 3,  MarEn = 4,  ZEn = 5;
   localparam int PcEn = 6,   MdrEn = 7,   Rd = 8,      IrEn = 9,    YEn = 10,   PcInc = 11;
   localparam int LoEn = 12,  HiEn = 13,   RIn = 14,    ROut = 15,   Gra = 16,   Grb = 17;
   localparam int Grc = 18,   BaOut = 19,  CSx = 20,    RamWr = 21;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] ir;
   logic        stop;
   logic        resume;
   logic [22:0] ctl;
   logic [4:0]  alu_op;
   logic [3:0]  step;
   logic        running;
   logic        illegal;

   int n_checks = 0;
   int n_errors = 0;

   control_sequencer #(
      .OPCODE_W   (5),
      .STEP_CYCLES(Sc)
   ) dut (
      .clk    (clk),
      .clr    (clr),
      .ir     (ir),
      .stop   (stop),
      .resume (resume),
      .ctl    (ctl),
      .alu_op (alu_op),
      .step   (step),
      .running(running),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int last_t(input logic [4:0] op);
      if (op == 5'b11011) return 2;
      if (op inside {5'b00000, 5'b00010}) return 7;
      if (op inside {5'b01111, 5'b10000}) return 6;
      if (op inside {5'b10001, 5'b10010}) return 4;
      if (op inside {5'b00001, [5'b00011:5'b01110]}) return 5;
      return 3;
   endfunction

   function automatic logic [22:0] exp_ctl(input logic [4:0] op, input int t);
      logic [22:0] w = '0;
      if (t == 0) begin
         w[PcOut] = 1'b1; w[MarEn] = 1'b1; w[PcInc] = 1'b1; w[ZEn] = 1'b1;
      end else if (t == 1) begin
         w[ZloOut] = 1'b1; w[PcEn] = 1'b1; w[Rd] = 1'b1; w[MdrEn] = 1'b1;
      end else if (t == 2) begin
         w[MdrOut] = 1'b1; w[IrEn] = 1'b1;
      end else if (op inside {[5'b00011:5'b01011]}) begin
         if (t == 3) begin w[Grb] = 1'b1; w[ROut] = 1'b1; w[YEn] = 1'b1; end
         if (t == 4) begin w[Grc] = 1'b1; w[ROut] = 1'b1; w[ZEn] = 1'b1; end
         if (t == 5) begin w[ZloOut] = 1'b1; w[Gra] = 1'b1; w[RIn] = 1'b1; end
      end else if (op inside {5'b00001, 5'b01100, 5'b01101, 5'b01110}) begin
         if (t == 3) begin
            w[Grb] = 1'b1; w[YEn] = 1'b1;
            if (op == 5'b00001) w[BaOut] = 1'b1; else w[ROut] = 1'b1;
         end
         if (t == 4) begin w[CSx] = 1'b1; w[ZEn] = 1'b1; end
         if (t == 5) begin w[ZloOut] = 1'b1; w[Gra] = 1'b1; w[RIn] = 1'b1; end
      end else if (op inside {5'b00000, 5'b00010}) begin
         if (t == 3) begin w[Grb] = 1'b1; w[BaOut] = 1'b1; w[YEn] = 1'b1; end
         if (t == 4) begin w[CSx] = 1'b1; w[ZEn] = 1'b1; end
         if (t == 5) begin w[ZloOut] = 1'b1; w[MarEn] = 1'b1; end
         if (op == 5'b00000) begin
            if (t == 6) begin w[Rd] = 1'b1; w[MdrEn] = 1'b1; end
            if (t == 7) begin w[MdrOut] = 1'b1; w[Gra] = 1'b1; w[RIn] = 1'b1; end
         end else begin
            if (t == 6) begin w[Gra] = 1'b1; w[ROut] = 1'b1; w[MdrEn] = 1'b1; end
            if (t == 7) w[RamWr] = 1'b1;
         end
      end else if (op inside {5'b01111, 5'b10000}) begin
         if (t == 3) begin w[Gra] = 1'b1; w[ROut] = 1'b1; w[YEn] = 1'b1; end
         if (t == 4) begin w[Grb] = 1'b1; w[ROut] = 1'b1; w[ZEn] = 1'b1; end
         if (t == 5) begin w[ZloOut] = 1'b1; w[LoEn] = 1'b1; end
         if (t == 6) begin w[ZhiOut] = 1'b1; w[HiEn] = 1'b1; end
      end else if (op inside {5'b10001, 5'b10010}) begin
         if (t == 3) begin w[Grb] = 1'b1; w[ROut] = 1'b1; w[ZEn] = 1'b1; end
         if (t == 4) begin w[ZloOut] = 1'b1; w[Gra] = 1'b1; w[RIn] = 1'b1; end
      end
      return w;
   endfunction

   // m_mode: 0 = in reset, 1 = stepping, 2 = halted
   int m_mode = 0;
   int m_t = 0;
   int m_c = 0;

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         m_mode <= 0; m_t <= 0; m_c <= 0;
      end else if (m_mode == 0) begin
         m_mode <= 1; m_t <= 0; m_c <= 0;
      end else if (m_mode == 2) begin
         if (resume && !stop) begin m_mode <= 1; m_t <= 0; m_c <= 0; end
      end else if (m_c < Sc - 1) begin
         m_c <= m_c + 1;
      end else begin
         m_c <= 0;
         if (m_t < last_t(ir[31:27])) begin
            m_t <= m_t + 1;
         end else begin
            m_t <= 0;
            if (stop || ir[31:27] == 5'b11011) m_mode <= 2;
         end
      end
   end

   function automatic logic [31:0] exp_alu(input int mode, input int t, input logic [4:0] op);
      if (mode != 1) return 32'd0;
      if (t == 0) return 32'd3;
      if (t >= 3) return {27'd0, op};
      return 32'd0;
   endfunction

   always @(negedge clk) begin
      check("m_ctl", {9'd0, ctl}, (m_mode == 1) ? {9'd0, exp_ctl(ir[31:27], m_t)} : 32'd0);
      check("m_step", {28'd0, step}, (m_mode == 1) ? m_t : 0);
      check("m_running", {31'd0, running}, (m_mode == 1) ? 32'd1 : 32'd0);
      check("m_illegal", {31'd0, illegal},
            (m_mode == 1 && m_t == 3 && m_c == 0 && last_t(ir[31:27]) == 3) ? 32'd1 : 32'd0);
      check("m_alu_op", {27'd0, alu_op}, exp_alu(m_mode, m_t, ir[31:27]));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] instr(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [18:0] c);
      return {op, ra, rb, c};
   endfunction

   initial begin
      int n_rw;
      int n_ill;
      int n_nz;
      clr = 1'b0; ir = '0; stop = 1'b0; resume = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctl", {9'd0, ctl}, 32'd0);
      check("rst_alu_op", {27'd0, alu_op}, 32'd0);
      check("rst_step", {28'd0, step}, 32'd0);
      check("rst_running", {31'd0, running}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);

      // ldi r3,0x15
      ir = instr(5'b00001, 4'd3, 4'd0, 19'h15);
      clr = 1'b1;
      tick();
      check("ldi_t0_ctl", {9'd0, ctl}, 32'h000831);
      repeat (15) tick();
      check("ldi_t5_ctl", {9'd0, ctl}, 32'h014002);
      check("ldi_t5_step", {28'd0, step}, 32'd5);
      repeat (3) tick();
      check("ldi_wrap_step", {28'd0, step}, 32'd0);

      // andi r2,r3,0x25
      ir = instr(5'b01101, 4'd2, 4'd3, 19'h25);
      repeat (9) tick();
      check("andi_t3_ctl", {9'd0, ctl}, 32'h028400);
      repeat (3) tick();
      check("andi_t4_ctl", {9'd0, ctl}, 32'h100020);
      check("andi_t4_alu", {27'd0, alu_op}, 32'h0d);
      repeat (6) tick();

      // st: ram_write must last exactly one T-step
      ir = instr(5'b00010, 4'd4, 4'd5, 19'h10);
      n_rw = 0;
      for (int i = 0; i < 24; i++) begin
         if (ctl[RamWr]) n_rw++;
         tick();
      end
      check("st_ramwr_clocks", n_rw, 32'd3);

      // undefined opcode 11111
      ir = instr(5'b11111, 4'd0, 4'd0, 19'h0);
      n_ill = 0;
      n_nz = 0;
      for (int i = 0; i < 12; i++) begin
         if (illegal) n_ill++;
         if (i >= 9 && ctl != '0) n_nz++;
         tick();
      end
      check("ill_pulse_clocks", n_ill, 32'd1);
      check("ill_ctl_nonzero", n_nz, 32'd0);
      check("ill_next_step", {28'd0, step}, 32'd0);
      check("ill_next_running", {31'd0, running}, 32'd1);

      // add with stop raised in T4
      ir = instr(5'b00011, 4'd1, 4'd2, 19'h18000);
      repeat (12) tick();
      stop = 1'b1;
      repeat (6) tick();
      check("halt_running", {31'd0, running}, 32'd0);
      check("halt_ctl", {9'd0, ctl}, 32'd0);
      check("halt_step", {28'd0, step}, 32'd0);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      check("halt_stop_resume", {31'd0, running}, 32'd0);
      stop = 1'b0;
      resume = 1'b1;
      tick();
      resume = 1'b0;
      check("resume_step", {28'd0, step}, 32'd0);
      check("resume_running", {31'd0, running}, 32'd1);
      check("resume_ctl", {9'd0, ctl}, 32'h000831);

      // ld with a stray resume in T1, then clr mid-T6
      ir = instr(5'b00000, 4'd6, 4'd1, 19'h8);
      repeat (3) tick();
      resume = 1'b1;
      tick();
      resume = 1'b0;
      repeat (15) tick();
      check("ld_t6_step", {28'd0, step}, 32'd6);
      #2 clr = 1'b0;
      #1;
      check("clr_ctl", {9'd0, ctl}, 32'd0);
      check("clr_alu_op", {27'd0, alu_op}, 32'd0);
      check("clr_step", {28'd0, step}, 32'd0);
      check("clr_running", {31'd0, running}, 32'd0);
      check("clr_illegal", {31'd0, illegal}, 32'd0);
      tick();
      clr = 1'b1;
      tick();
      check("rel_step", {28'd0, step}, 32'd0);
      check("rel_running", {31'd0, running}, 32'd1);
      check("rel_alu_op", {27'd0, alu_op}, 32'd3);

      // mul, neg, then halt opcode
      ir = instr(5'b01111, 4'd7, 4'd8, 19'h0);
      repeat (21) tick();
      ir = instr(5'b10001, 4'd9, 4'd10, 19'h0);
      repeat (15) tick();
      ir = instr(5'b11011, 4'd0, 4'd0, 19'h0);
      repeat (9) tick();
      check("hlt_op_running", {31'd0, running}, 32'd0);
      resume = 1'b1;
      ir = instr(5'b00100, 4'd1, 4'd2, 19'h0);
      tick();
      resume = 1'b0;
      check("hlt_op_resume", {31'd0, running}, 32'd1);
      repeat (18) tick();
      check("sub_wrap_step", {28'd0, step}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 5, SHALL set the opcode field width taken from ir[31:31-OPCODE_W+1].
REQ-002 Parameter STEP_CYCLES, default 2, SHALL set the clocks each T-step is held; legal range is 1..8.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 clr  in  1  reset; asynchronous, active-low.
REQ-005 ir  in  32  instruction register contents, valid from T3 onward.
REQ-006 stop  in  1  level request to halt at the next instruction boundary.
REQ-007 resume  in  1  single-cycle pulse that leaves HALT.
REQ-008 ctl  out  CTL_W  one-hot-per-signal control word, bit order per cu_pkg: pc_out, zlo_out, zhi_out, mdr_out, mar_enable, z_enable, pc_enable, mdr_enable, read, ir_enable, y_enable, pc_increment, lo_enable, hi_enable, r_in, r_out, gra, grb, grc, ba_out, c_sign_extended_out, ram_write, con_enable.
REQ-009 alu_op  out  OPCODE_W  opcode forwarded to the ALU; valid while z_enable is asserted.
REQ-010 step  out  4  current T-step index, 0..7.
REQ-011 running  out  1  high in every state except HALT and RESET.
REQ-012 illegal  out  1  one-clock pulse on an undefined opcode.

Function
REQ-013 States SHALL be RESET, T0..T7 and HALT; RESET SHALL go to T0 on the first clock after clr deasserts.
REQ-014 A cycle counter SHALL hold each T-step for exactly STEP_CYCLES clocks, and ctl SHALL remain constant across those clocks.
REQ-015 Fetch SHALL be common to all opcodes: T0 asserts pc_out, mar_enable, pc_increment and z_enable; T1 asserts zlo_out, pc_enable, read and mdr_enable; T2 asserts mdr_out and ir_enable.
REQ-016 Reg-reg ALU ops (add, sub, and, or, shr, shra, shl, ror, rol) SHALL sequence as: T3 grb, r_out, y_enable; T4 grc, r_out, z_enable; T5 zlo_out, gra, r_in; then T0.
REQ-017 addi, andi and ori SHALL sequence as: T3 grb, r_out, y_enable; T4 c_sign_extended_out, z_enable; T5 zlo_out, gra, r_in.
REQ-018 ldi SHALL follow REQ-017 with ba_out replacing r_out in T3.
REQ-019 ld SHALL sequence as: T3 grb, ba_out, y_enable; T4 c_sign_extended_out, z_enable; T5 zlo_out, mar_enable; T6 read, mdr_enable; T7 mdr_out, gra, r_in.
REQ-020 st SHALL share T3-T5 with ld, then T6 gra, r_out, mdr_enable; T7 ram_write.
REQ-021 mul and div SHALL sequence as: T3 gra, r_out, y_enable; T4 grb, r_out, z_enable; T5 zlo_out, lo_enable; T6 zhi_out, hi_enable.
REQ-022 neg and not SHALL sequence as: T3 grb, r_out, z_enable; T4 zlo_out, gra, r_in.
REQ-023 The halt opcode SHALL enter HALT after T2; in HALT, ctl SHALL be all-zero.
REQ-024 An undefined opcode SHALL pulse illegal on the first T3 clock, drive ctl to zero, and return to T0 after STEP_CYCLES clocks.
REQ-025 stop SHALL be sampled only on the last clock of an instruction's final step; if high, the next state SHALL be HALT instead of T0.
REQ-026 resume in HALT SHALL go to T0; resume outside HALT SHALL be ignored; resume and stop high together in HALT SHALL stay in HALT.
REQ-027 alu_op SHALL equal the ir opcode during T3-T7 and add_opcode during T0, so that the PC increment path is selected.

Reset
REQ-028 With clr low, the block SHALL immediately enter RESET with ctl=0, alu_op=0, step=0, running=0, illegal=0 and the cycle counter at 0, including when clr falls mid-instruction.

Structure
REQ-029 Package cu_pkg SHALL hold the opcode constants (ld=00000 … not=10010, halt=11011), CTL_W, the ctl bit indices and the state enumeration.
REQ-030 A sub-module step_timer SHALL contain the STEP_CYCLES counter and produce a step_done strobe.

Verification
REQ-031 The bench SHALL load ldi r3,0x15 and check that gra, r_in and zlo_out are high during T5 and that step returns to 0 after 6×STEP_CYCLES clocks.
REQ-032 The bench SHALL load andi r2,r3,0x25 and check that T3 asserts grb, r_out and y_enable, and that T4 asserts c_sign_extended_out and z_enable with alu_op=01101.
REQ-033 The bench SHALL load st with STEP_CYCLES=3 and check that ram_write is high for exactly 3 clocks in T7.
REQ-034 The bench SHALL load opcode 11111 and check that illegal pulses for 1 clock, ctl=0, and T0 follows.
REQ-035 The bench SHALL raise stop during T4 of add and check that HALT is entered after T5, running=0, and that resume leads to T0 on the next clock.
REQ-036 The bench SHALL pull clr low mid-T6 of ld and check that all outputs are 0 asynchronously and that T0 follows release.
